output_scheduler: RTL and testbench
===================================

OUTPUT_SCHEDULER -- requirements
Module: output_scheduler

Interface
REQ-001 Parameter NPORTS, default 5, number of router ports; index 0=north, 1=south, 2=east, 3=west, 4=local.
REQ-002 Parameter CREDIT_DEPTH, default 4, downstream input-buffer depth in flits, i.e. the initial credits per output.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 req_valid_i  input  NPORTS  per input queue: a head flit is present.
REQ-006 req_port_i  input  NPORTS x 3  per input: destination output index of the head flit.
REQ-007 credit_incr_i  input  NPORTS  per output: downstream returned one credit this cycle.
REQ-008 grant_o  output  NPORTS  per input: pop strobe; the head flit is transferred this cycle.
REQ-009 out_valid_o  output  NPORTS  per output: a flit is driven through the crossbar this cycle.
REQ-010 sel_o  output  NPORTS x 3  per output: index of the input driving it; valid only when out_valid_o is high.
REQ-011 credit_o  output  NPORTS x 3  per output: current credit count.
REQ-012 err_o  output  1  sticky error flag.

Function
REQ-013 Eligibility: input i requests output j when req_valid_i[i]=1, req_port_i[i]=j<NPORTS and grant_o[i]=0 in the current cycle.
REQ-014 Gating: output j arbitrates only when credit[j]>0.
REQ-015 Arbitration: output j picks the first eligible requester at or after rr_ptr[j], searching upward modulo NPORTS.
REQ-016 Grants are registered: a decision made in cycle t drives grant_o, out_valid_o and sel_o in cycle t+1, giving 1-cycle latency.
REQ-017 Exclusivity: at most one grant per output per cycle; an input requests one output, so it receives at most one grant.
REQ-018 Back-to-back: an input granted in cycle t is ineligible in cycle t, so it cannot win two consecutive cycles; a requester must hold its request (sustained requests) until granted.
REQ-019 Pointer update: on a grant from output j to input i, rr_ptr[j] becomes (i+1) mod NPORTS; with no grant it is unchanged.
REQ-020 Credits: credit[j] decrements by 1 on each grant to j and increments by 1 on credit_incr_i[j].
REQ-021 Simultaneous credit increment and grant on the same output leave credit[j] unchanged.
REQ-022 Credit width is 3 bits, range 0..CREDIT_DEPTH.
REQ-023 Credit overflow: credit_incr_i[j] when credit[j]=CREDIT_DEPTH and no grant occurs saturates the count and sets err_o.
REQ-024 Invalid destination: req_valid_i[i]=1 with req_port_i[i]>=NPORTS is never granted and sets err_o.
REQ-025 err_o, once set, stays set until reset.
REQ-026 Credit updates take effect for eligibility in the cycle after they occur; no combinational path runs from credit_incr_i to grant_o.

Reset
REQ-027 While rst=0: grant_o=0, out_valid_o=0, sel_o=0, credit[*]=CREDIT_DEPTH (credit_o=4), rr_ptr[*]=0, err_o=0.
REQ-028 Reset asserted mid-transfer drops all pending grants immediately and asynchronously; the first grant after rst rises appears no earlier than the second rising edge.

Structure
REQ-029 router_pkg holds NPORTS, CREDIT_DEPTH, the port-index enum (NORTH..LOCAL) and the 3-bit port_idx_t type.
REQ-030 Sub-module rr_arb5 is combinational: request vector plus pointer in, one-hot grant out; it is instantiated once per output.
REQ-031 All state lives in output_scheduler: grant and select registers, credit counters, pointers and err_o.

Verification
REQ-032 Reset, then input 4 requests output 0 continuously -> grant_o=5'b10000 and sel_o[0]=4 on alternate cycles starting cycle 2; credit_o[0] drops 4->0 after four grants, then no grants.
REQ-033 Inputs 0..3 all request output 2 with credits restored each cycle -> grant order 0,1,2,3,0 and rr_ptr[2] ends at 1.
REQ-034 With credit[1]=0, a request to output 1 gets no grant; a credit_incr_i[1] pulse -> grant on the second edge after the pulse, and credit returns to 0.
REQ-035 Credit increment and grant on output 3 in the same cycle -> credit_o[3] holds its value, e.g. 2 stays 2.
REQ-036 credit_incr_i[0] while credit_o[0]=4 -> stays 4 and err_o=1; req_port_i=5 with valid -> no grant and err_o=1; both persist until rst=0.
REQ-037 rst pulled low while grant_o is high -> grant_o=0 within the same cycle, credits return to 4 and pointers to 0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router types and constants: port count, credit depth, port-index
// enum and the small helpers used by the output scheduler.
package router_pkg;

   localparam int NPORTS       = 5;
   localparam int CREDIT_DEPTH = 4;
   localparam int PORT_W       = 3;
   localparam int CREDIT_W     = 3;

   typedef logic [PORT_W-1:0]   port_idx_t;
   typedef logic [CREDIT_W-1:0] credit_t;

   typedef enum port_idx_t {
      NORTH = 3'd0,
      SOUTH = 3'd1,
      EAST  = 3'd2,
      WEST  = 3'd3,
      LOCAL = 3'd4
   } port_e;

   // Round-robin successor of a port index, wrapping at n.
   function automatic port_idx_t next_ptr(port_idx_t cur, int n);
      return (int'(cur) + 1 >= n) ? '0 : port_idx_t'(int'(cur) + 1);
   endfunction

endpackage

// File: rtl/output_scheduler_if.sv
// Signal bundle between the input queues, downstream credit returns and the
// output scheduler; the scheduler sits on the slave side.
interface output_scheduler_if #(
   parameter int NPORTS = router_pkg::NPORTS
);
   import router_pkg::*;

   logic      [NPORTS-1:0] req_valid_i;
   port_idx_t [NPORTS-1:0] req_port_i;
   logic      [NPORTS-1:0] credit_incr_i;
   logic      [NPORTS-1:0] grant_o;
   logic      [NPORTS-1:0] out_valid_o;
   port_idx_t [NPORTS-1:0] sel_o;
   credit_t   [NPORTS-1:0] credit_o;
   logic                   err_o;

   modport master (
      output req_valid_i, req_port_i, credit_incr_i,
      input  grant_o, out_valid_o, sel_o, credit_o, err_o
   );

   modport slave (
      input  req_valid_i, req_port_i, credit_incr_i,
      output grant_o, out_valid_o, sel_o, credit_o, err_o
   );

endinterface

// File: rtl/output_scheduler_rr_arb5.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at
// or after ptr, searching upward modulo N.
module rr_arb5 #(
   parameter int N = router_pkg::NPORTS
) (
   input  logic [N-1:0]          req,
   input  router_pkg::port_idx_t ptr,
   output logic [N-1:0]          gnt
);
   import router_pkg::*;

   port_idx_t idx;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      gnt = '0;
      idx = '0;
      // Scan from the farthest offset down so the nearest requester wins last.
      for (int k = N - 1; k >= 0; k--) begin
         idx = port_idx_t'((int'(ptr) + k) % N);
         if (req[idx]) begin
            gnt      = '0;
            gnt[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/output_scheduler.sv
// Output scheduler: per-output credit-gated round-robin arbitration with
// registered grants (one-cycle latency) and a sticky error flag.
module output_scheduler #(
   parameter int NPORTS       = router_pkg::NPORTS,
   parameter int CREDIT_DEPTH = router_pkg::CREDIT_DEPTH
) (
   input logic               clk,
   input logic               rst,
   output_scheduler_if.slave bus
);
   import router_pkg::*;

   localparam credit_t MAX_CREDIT = credit_t'(CREDIT_DEPTH);
   localparam credit_t ONE_CREDIT = credit_t'(1);

   logic                   armed_q;
   logic      [NPORTS-1:0] grant_q, grant_d;
   logic      [NPORTS-1:0] out_valid_q, out_valid_d;
   port_idx_t [NPORTS-1:0] sel_q, sel_d;
   credit_t   [NPORTS-1:0] credit_q;
   port_idx_t              rr_ptr_q [NPORTS];
   logic                   err_q;

   logic      [NPORTS-1:0] eligible;
   logic      [NPORTS-1:0] overflow;
   logic                   bad_dest;
   logic      [NPORTS-1:0] arb_req [NPORTS];
   logic      [NPORTS-1:0] arb_gnt [NPORTS];

   // armed_q holds off decisions for the first edge after reset release.
   always_comb begin
      eligible = '0;
      bad_dest = 1'b0;
      for (int i = 0; i < NPORTS; i++) begin
         eligible[i] = armed_q && bus.req_valid_i[i] && !grant_q[i]
                       && (int'(bus.req_port_i[i]) < NPORTS);
         bad_dest    = bad_dest
                       || (bus.req_valid_i[i] && (int'(bus.req_port_i[i]) >= NPORTS));
      end
   end

   always_comb begin
      for (int j = 0; j < NPORTS; j++) begin
         arb_req[j] = '0;
         for (int i = 0; i < NPORTS; i++) begin
            arb_req[j][i] = eligible[i] && (int'(bus.req_port_i[i]) == j)
                            && (credit_q[j] != '0);
         end
      end
   end

   for (genvar j = 0; j < NPORTS; j++) begin : g_arb
      rr_arb5 #(.N(NPORTS)) u_arb (
         .req (arb_req[j]),
         .ptr (rr_ptr_q[j]),
         .gnt (arb_gnt[j])
      );
   end

   always_comb begin
      grant_d     = '0;
      out_valid_d = '0;
      sel_d       = '0;
      overflow    = '0;
      for (int j = 0; j < NPORTS; j++) begin
         out_valid_d[j] = |arb_gnt[j];
         for (int i = 0; i < NPORTS; i++) begin
            if (arb_gnt[j][i]) begin
               sel_d[j]   = port_idx_t'(i);
               grant_d[i] = 1'b1;
            end
         end
         // A returned credit that finds the counter full, with nothing spent, is lost.
         overflow[j] = bus.credit_incr_i[j] && !out_valid_d[j] && (credit_q[j] == MAX_CREDIT);
      end
   end

   // NOTE: state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         armed_q     <= 1'b0;
         grant_q     <= '0;
         out_valid_q <= '0;
         sel_q       <= '0;
         err_q       <= 1'b0;
         // NOTE: these arrays are a handful of flops, not RAM, so they are reset.
         for (int j = 0; j < NPORTS; j++) begin
            credit_q[j] <= MAX_CREDIT;
            rr_ptr_q[j] <= '0;
         end
      end else begin
         armed_q     <= 1'b1;
         grant_q     <= grant_d;
         out_valid_q <= out_valid_d;
         sel_q       <= sel_d;
         err_q       <= err_q | bad_dest | (|overflow);
         for (int j = 0; j < NPORTS; j++) begin
            if (out_valid_d[j]) rr_ptr_q[j] <= next_ptr(sel_d[j], NPORTS);
            unique case ({out_valid_d[j], bus.credit_incr_i[j]})
               2'b10:   credit_q[j] <= credit_q[j] - ONE_CREDIT;
               2'b01:   if (!overflow[j]) credit_q[j] <= credit_q[j] + ONE_CREDIT;
               default: ;
            endcase
         end
      end
   end

   assign bus.grant_o     = grant_q;
   assign bus.out_valid_o = out_valid_q;
   assign bus.sel_o       = sel_q;
   assign bus.credit_o    = credit_q;
   assign bus.err_o       = err_q;

endmodule

// File: tb/tb_output_scheduler.sv
// Randomised and directed bench for output_scheduler: a high-level reference
// model queues the expected outputs each cycle; a monitor pops and compares them.
module tb_output_scheduler;
   import router_pkg::*;

   localparam int N     = 5;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   output_scheduler_if #(.NPORTS(N)) bus ();

   output_scheduler #(.NPORTS(N), .CREDIT_DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic [N-1:0] grant;
      logic [N-1:0] outv;
      logic [2:0]   sel    [N];
      logic [2:0]   credit [N];
      logic         err;
   } exp_t;

   exp_t exp_q [$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   mon_en  = 1'b0;

   // Reference model state: what the outputs should show right now.
   int       m_credit [N];
   int       m_ptr    [N];
   int       m_sel    [N];
   bit [N-1:0] m_grant, m_outv;
   bit       m_err, m_armed;

   // Stimulus for the coming cycle.
   logic [N-1:0] s_valid, s_incr;
   logic [2:0]   s_port [N];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_stim();
      s_valid = '0;
      s_incr  = '0;
      for (int i = 0; i < N; i++) s_port[i] = 3'd0;
   endtask

   task automatic drive();
      bus.req_valid_i   = s_valid;
      bus.credit_incr_i = s_incr;
      for (int i = 0; i < N; i++) bus.req_port_i[i] = s_port[i];
   endtask

   task automatic model_reset();
      for (int j = 0; j < N; j++) begin
         m_credit[j] = DEPTH;
         m_ptr[j]    = 0;
         m_sel[j]    = 0;
      end
      m_grant = '0;
      m_outv  = '0;
      m_err   = 1'b0;
      m_armed = 1'b0;
   endtask

   // Queue the current expectation, apply stimulus, advance the model one edge.
   task automatic step();
      exp_t       e;
      bit [N-1:0] win_in, win_out;
      int         win_sel [N];
      int         c;
      bit         found;
      e.grant = m_grant;
      e.outv  = m_outv;
      e.err   = m_err;
      for (int j = 0; j < N; j++) begin
         e.sel[j]    = 3'(m_sel[j]);
         e.credit[j] = 3'(m_credit[j]);
      end
      exp_q.push_back(e);
      drive();

      win_in  = '0;
      win_out = '0;
      for (int j = 0; j < N; j++) begin
         win_sel[j] = 0;
         found      = 1'b0;
         if (m_armed && m_credit[j] > 0) begin
            for (int k = 0; k < N; k++) begin
               int i;
               i = (m_ptr[j] + k) % N;
               if (!found && s_valid[i] && int'(s_port[i]) == j && !m_grant[i]) begin
                  found      = 1'b1;
                  win_in[i]  = 1'b1;
                  win_out[j] = 1'b1;
                  win_sel[j] = i;
               end
            end
         end
      end
      for (int j = 0; j < N; j++) begin
         c = m_credit[j] - (win_out[j] ? 1 : 0) + (s_incr[j] ? 1 : 0);
         if (c > DEPTH) begin
            c     = DEPTH;
            m_err = 1'b1;
         end
         m_credit[j] = c;
         if (win_out[j]) m_ptr[j] = (win_sel[j] + 1) % N;
         m_sel[j] = win_sel[j];
      end
      for (int i = 0; i < N; i++)
         if (s_valid[i] && int'(s_port[i]) >= N) m_err = 1'b1;
      m_grant = win_in;
      m_outv  = win_out;
      m_armed = 1'b1;

      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(string tag);
      check({tag, "_grant"}, bus.grant_o, '0);
      check({tag, "_out_valid"}, bus.out_valid_o, '0);
      check({tag, "_sel"}, bus.sel_o, '0);
      check({tag, "_err"}, bus.err_o, '0);
      for (int j = 0; j < N; j++)
         check($sformatf("%s_credit[%0d]", tag, j), bus.credit_o[j], DEPTH);
   endtask

   // Asserts rst immediately (asynchronously), holds it two edges, releases at posedge+1.
   task automatic apply_reset();
      mon_en = 1'b0;
      exp_q.delete();
      clear_stim();
      drive();
      rst = 1'b0;
      #1;
      check_reset_state("rst_async");
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("rst_held");
      rst    = 1'b1;
      mon_en = 1'b1;
   endtask

   initial begin : monitor
      forever begin
         exp_t e;
         @(negedge clk);
         if (mon_en && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_grant", bus.grant_o, e.grant);
            check("sb_out_valid", bus.out_valid_o, e.outv);
            check("sb_err", bus.err_o, e.err);
            for (int j = 0; j < N; j++) begin
               check($sformatf("sb_credit[%0d]", j), bus.credit_o[j], e.credit[j]);
               if (e.outv[j]) check($sformatf("sb_sel[%0d]", j), bus.sel_o[j], e.sel[j]);
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int order [$];
      int exp_order [5];
      int n_grants;
      exp_order = '{0, 1, 2, 3, 0};
      clear_stim();
      drive();
      @(posedge clk);
      #1;
      apply_reset();

      // Single source draining output 0: grants on alternate cycles until credit runs out.
      n_grants  = 0;
      s_valid[4] = 1'b1;
      s_port[4]  = 3'd0;
      repeat (12) begin
         step();
         if (bus.grant_o == 5'b10000) n_grants++;
      end
      check("drain_grant_count", n_grants, 4);
      check("drain_credit0", bus.credit_o[0], 0);
      check("drain_no_grant", bus.grant_o, '0);

      // Four inputs contend for output 2 with credits returned after each grant.
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         s_valid[i] = 1'b1;
         s_port[i]  = 3'd2;
      end
      repeat (6) begin
         s_incr[2] = m_outv[2];
         step();
         for (int i = 0; i < N; i++) if (bus.grant_o[i]) order.push_back(i);
      end
      check("rr_order_len", order.size(), 5);
      for (int k = 0; k < 5; k++)
         check($sformatf("rr_order[%0d]", k), (k < order.size()) ? order[k] : -1, exp_order[k]);
      s_valid   = '0;
      s_incr[2] = m_outv[2];
      step();
      s_incr    = '0;
      s_valid[0] = 1'b1;
      s_valid[1] = 1'b1;
      step();
      check("rr_ptr_resume", bus.grant_o, 5'b00010);
      clear_stim();
      step();

      // Output 1 starved of credit, then a single credit return.
      apply_reset();
      s_valid[3] = 1'b1;
      s_port[3]  = 3'd1;
      repeat (12) step();
      check("starve_credit1", bus.credit_o[1], 0);
      check("starve_no_grant", bus.grant_o, '0);
      s_incr[1] = 1'b1;
      step();
      s_incr[1] = 1'b0;
      check("credit_ret_first_edge", bus.grant_o, '0);
      check("credit_ret_credit1", bus.credit_o[1], 1);
      step();
      check("credit_ret_second_edge", bus.grant_o, 5'b01000);
      check("credit_ret_back_to_0", bus.credit_o[1], 0);

      // Credit return coinciding with a grant on output 3.
      apply_reset();
      s_valid[0] = 1'b1;
      s_port[0]  = 3'd3;
      repeat (5) step();
      check("simul_before", bus.credit_o[3], 2);
      s_incr[3] = 1'b1;
      step();
      s_incr[3] = 1'b0;
      check("simul_grant", bus.grant_o, 5'b00001);
      check("simul_credit3", bus.credit_o[3], 2);

      // Credit overflow and invalid destination both latch err_o.
      apply_reset();
      s_incr[0] = 1'b1;
      step();
      s_incr[0] = 1'b0;
      check("ovf_credit0", bus.credit_o[0], DEPTH);
      check("ovf_err", bus.err_o, 1);
      repeat (3) step();
      check("ovf_err_sticky", bus.err_o, 1);
      apply_reset();
      s_valid[2] = 1'b1;
      s_port[2]  = 3'd5;
      repeat (4) step();
      check("bad_dest_no_grant", bus.grant_o, '0);
      check("bad_dest_no_out", bus.out_valid_o, '0);
      check("bad_dest_err", bus.err_o, 1);

      // Reset pulled while a grant is being presented.
      apply_reset();
      s_valid[4] = 1'b1;
      s_port[4]  = 3'd0;
      repeat (2) step();
      check("mid_rst_grant_before", bus.grant_o, 5'b10000);
      #1;
      apply_reset();

      // Random traffic with legal destinations and mostly non-overflowing credit returns.
      repeat (300) begin
         for (int i = 0; i < N; i++) begin
            s_valid[i] = ($urandom_range(0, 3) != 0);
            s_port[i]  = 3'($urandom_range(0, N - 1));
            s_incr[i]  = (m_credit[i] < DEPTH) && ($urandom_range(0, 2) == 0);
         end
         step();
      end

      // Fully random traffic including invalid destinations and overflows.
      repeat (150) begin
         for (int i = 0; i < N; i++) begin
            s_valid[i] = ($urandom_range(0, 1) != 0);
            s_port[i]  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7))
                                                      : 3'($urandom_range(0, N - 1));
            s_incr[i]  = ($urandom_range(0, 3) == 0);
         end
         step();
      end

      clear_stim();
      repeat (3) step();
      @(negedge clk);
      #1;
      check("sb_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
